// File: rtl/mul_accum.sv
// mul_accum: sequencer and shift-add accumulator for the binary-serial
// signed multiplier. Walks the bit index 0..WIDTH-1 into mul_inner, takes
// back the partial products one edge later, and folds them into a signed
// 2*WIDTH-bit product (MSB partial product carries negative weight).
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   en       clock enable, en=0 freezes all state
//   clr      synchronous clear, wins over en
//   i_start  request a new multiplication (accepted only when idle)
//   o_idx    bit index driven to mul_inner (combinational, 0 unless running)
//   i_pp     partial product returned by mul_inner
//   o_busy   high while a product is in progress
//   o_valid  one-enabled-cycle pulse marking a new o_data
//   o_data   signed product, held until next completion or clear
module mul_accum #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic               i_start,
  output logic [DEPTH-1:0]   o_idx,
  input  logic [2*WIDTH-1:0] i_pp,
  output logic               o_busy,
  output logic               o_valid,
  output logic [2*WIDTH-1:0] o_data
);

  localparam int unsigned      PW   = 2 * WIDTH;
  localparam logic [DEPTH-1:0] LAST = DEPTH'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic             pp_vld_q, pp_vld_d;
  logic [DEPTH-1:0] pp_k_q, pp_k_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [PW-1:0]    data_q, data_d;

  logic [PW-1:0]    pp_term;
  logic [PW-1:0]    acc_upd;

  // Index goes out only while running so mul_inner parks at 0 otherwise
  assign o_idx = (state_q == RUN) ? cnt_q : '0;

  // Weighted partial product; the top bit of a two's-complement operand is subtracted
  always_comb begin
    pp_term = i_pp << pp_k_q;
    acc_upd = acc_q;
    if (pp_vld_q) begin
      if (pp_k_q == LAST) acc_upd = acc_q - pp_term;
      else                acc_upd = acc_q + pp_term;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_upd;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    data_d   = data_q;
    // Mirror of mul_inner's index register: it captures o_idx on the same edge
    pp_vld_d = (state_q == RUN);
    pp_k_d   = o_idx;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RUN;
          cnt_d   = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == LAST) state_d = DRAIN;
        else               cnt_d   = cnt_q + DEPTH'(1);
      end
      DRAIN: begin
        // This edge folds in the last (MSB) partial product
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
        valid_d = 1'b1;
        data_d  = acc_upd;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      pp_vld_q <= 1'b0;
      pp_k_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else if (clr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      pp_vld_q <= 1'b0;
      pp_k_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else if (en) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      pp_vld_q <= pp_vld_d;
      pp_k_q   <= pp_k_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule

// File: tb/tb_mul_accum.sv
// Bench for mul_accum with a behavioural stand-in for mul_inner; products
// are checked against plain signed a*b.
module tb_mul_accum;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned PW    = 2 * WIDTH;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             clr;
  logic             i_start;
  logic [DEPTH-1:0] o_idx;
  logic [PW-1:0]    i_pp;
  logic             o_busy;
  logic             o_valid;
  logic [PW-1:0]    o_data;

  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic [DEPTH-1:0]        idx_q;

  int errors;
  int checks;

  mul_accum #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
    .i_start (i_start),
    .o_idx   (o_idx),
    .i_pp    (i_pp),
    .o_busy  (o_busy),
    .o_valid (o_valid),
    .o_data  (o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mul_inner stand-in: registered index, partial product = sign-extended b or 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   idx_q <= '0;
    else if (clr) idx_q <= '0;
    else if (en)  idx_q <= o_idx;
  end
  assign i_pp = a[idx_q] ? {{WIDTH{b[WIDTH-1]}}, b} : '0;

  function automatic logic [PW-1:0] ref_prod(input logic signed [WIDTH-1:0] x,
                                             input logic signed [WIDTH-1:0] y);
    int p;
    p = int'(x) * int'(y);
    return PW'(p);
  endfunction

  // Issue a start and wait for o_valid; edges counts enabled edges after acceptance
  task automatic issue_and_wait(output int edges, output int busy_cnt, output int idx_bad);
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    edges = 0; busy_cnt = 0; idx_bad = 0;
    while (o_valid !== 1'b1 && edges < 40) begin
      if (o_busy === 1'b1) busy_cnt++;
      if (edges < 8 && o_idx !== DEPTH'(edges)) idx_bad++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; i_start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_busy, o_valid, o_data, o_idx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b valid=%0b data=%h idx=%0d, required all 0",
               o_busy, o_valid, o_data, o_idx);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int e, bc, ib;
    a = 8'sd3; b = 8'sd5;
    issue_and_wait(e, bc, ib);
    checks++;
    if (e !== 9) begin errors++; $display("FAIL basic_latency: edges=%0d required 9", e); end
    checks++;
    if (bc !== 9) begin errors++; $display("FAIL basic_busy_len: busy=%0d required 9", bc); end
    checks++;
    if (ib !== 0) begin errors++; $display("FAIL basic_idx_seq: bad=%0d required 0", ib); end
    checks++;
    if (o_data !== 16'd15 || o_busy !== 1'b0) begin
      errors++; $display("FAIL basic_product: data=%0d busy=%0b required 15 busy 0", o_data, o_busy);
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_data !== 16'd15) begin
      errors++; $display("FAIL basic_pulse: valid=%0b data=%0d required 0 and held 15", o_valid, o_data);
    end
  endtask

  task automatic test_signed;
    int e, bc, ib;
    a = -8'sd128; b = -8'sd128;
    issue_and_wait(e, bc, ib);
    checks++;
    if (o_data !== 16'd16384 || e !== 9) begin
      errors++; $display("FAIL signed_min_min: data=%0d edges=%0d required 16384 in 9", o_data, e);
    end
    a = -8'sd1; b = 8'sd127;
    issue_and_wait(e, bc, ib);
    checks++;
    if (o_data !== ref_prod(-8'sd1, 8'sd127) || e !== 9) begin
      errors++; $display("FAIL signed_msb_sub: data=%0d edges=%0d required %0d", $signed(o_data), e, -127);
    end
  endtask

  task automatic test_enable_gating;
    int en_edges, iter, frozen_bad;
    logic [DEPTH+PW+1:0] snap;
    a = 8'sd3; b = 8'sd5;
    @(negedge clk);
    i_start = 1'b1; en = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    en_edges = 0; iter = 0; frozen_bad = 0;
    while (o_valid !== 1'b1 && iter < 60) begin
      en = iter[0];
      snap = {o_busy, o_valid, o_data, o_idx};
      @(negedge clk);
      if (en) en_edges++;
      else if ({o_busy, o_valid, o_data, o_idx} !== snap) frozen_bad++;
      iter++;
    end
    checks++;
    if (en_edges !== 9 || o_data !== 16'd15) begin
      errors++; $display("FAIL en_gated_product: en_edges=%0d data=%0d required 9 and 15", en_edges, o_data);
    end
    checks++;
    if (frozen_bad !== 0) begin
      errors++; $display("FAIL en_freeze: changed_while_en0=%0d required 0", frozen_bad);
    end
    en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 16'd15) begin
      errors++; $display("FAIL en_hold_valid: valid=%0b data=%0d required 1 and 15", o_valid, o_data);
    end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL en_valid_drop: valid=%0b required 0", o_valid);
    end
  endtask

  task automatic test_clear;
    int e, bc, ib, seen;
    a = 8'sd3; b = 8'sd5;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    clr = 1'b1; en = 1'b0;
    @(negedge clk);
    clr = 1'b0; en = 1'b1;
    checks++;
    if ({o_busy, o_valid, o_data, o_idx} !== '0) begin
      errors++;
      $display("FAIL clr_outputs: busy=%0b valid=%0b data=%h idx=%0d required all 0",
               o_busy, o_valid, o_data, o_idx);
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_valid === 1'b1 || o_busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL clr_abandon: activity=%0d required 0", seen); end
    a = 8'sd7; b = -8'sd9;
    issue_and_wait(e, bc, ib);
    checks++;
    if (o_data !== ref_prod(8'sd7, -8'sd9) || e !== 9) begin
      errors++; $display("FAIL clr_fresh: data=%0d edges=%0d required -63 in 9", $signed(o_data), e);
    end
  endtask

  task automatic test_back_to_back;
    int e, bc, ib, edges, stray;
    a = 8'sd3; b = 8'sd5;
    issue_and_wait(e, bc, ib);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 16'd15) begin
      errors++; $display("FAIL b2b_first: valid=%0b data=%0d required 1 and 15", o_valid, o_data);
    end
    a = 8'sd2; b = -8'sd3; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept: valid=%0b busy=%0b required 0 and 1", o_valid, o_busy);
    end
    edges = 0;
    while (o_valid !== 1'b1 && edges < 40) begin
      i_start = (edges == 3 || edges == 5);
      @(negedge clk);
      edges++;
    end
    i_start = 1'b0;
    checks++;
    if (edges !== 9 || o_data !== ref_prod(8'sd2, -8'sd3)) begin
      errors++; $display("FAIL b2b_second: edges=%0d data=%0d required 9 and -6", edges, $signed(o_data));
    end
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_busy === 1'b1) stray++;
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL b2b_ignored_start: busy_cycles=%0d required 0", stray); end
  endtask

  task automatic test_async_reset;
    int seen;
    a = 8'sd7; b = 8'sd7;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_valid, o_data, o_idx} !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%0b valid=%0b data=%h idx=%0d required all 0",
               o_busy, o_valid, o_data, o_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_valid === 1'b1 || o_busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL async_abandon: activity=%0d required 0", seen); end
  endtask

  task automatic test_random;
    int e, bc, ib, bad;
    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      issue_and_wait(e, bc, ib);
      checks++;
      if (o_data !== ref_prod(a, b) || e !== 9) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_prod: a=%0d b=%0d data=%0d edges=%0d required %0d in 9",
                   a, b, $signed(o_data), e, $signed(ref_prod(a, b)));
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_signed();
    test_enable_gating();
    test_clear();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
